// File: rtl/hazard_control_unit.sv
// hazard_control_unit: load-use stall, branch flush and memory freeze control with saturating event counters.
module hazard_control_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int ZERO_REG_EXEMPT = 1,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] ID_EX_rt,
  input  logic                  ID_EX_mem_read,
  input  logic [REG_ADDR_W-1:0] IF_ID_rs,
  input  logic [REG_ADDR_W-1:0] IF_ID_rt,
  input  logic [1:0]            branch,
  input  logic                  equal,
  input  logic                  mem_busy,
  output logic                  pc_write,
  output logic                  IF_ID_write,
  output logic                  mux_hz_unit,
  output logic                  flush,
  output logic [CNT_W-1:0]      stall_events,
  output logic [CNT_W-1:0]      flush_events
);
  typedef enum logic [1:0] {IDLE, LOAD_STALL, FLUSH} state_t;
  state_t state, state_n;
  logic [3:0] rem, rem_n;
  logic hz, taken, do_stall, do_flush, stall_inc, flush_inc;
  assign hz = ID_EX_mem_read && (IF_ID_rs == ID_EX_rt || IF_ID_rt == ID_EX_rt) &&
              !(ZERO_REG_EXEMPT != 0 && ID_EX_rt == '0);
  assign taken = (branch == 2'b01 && equal) || (branch == 2'b10 && !equal) || branch == 2'b11;
  // Mealy in IDLE: the first stall/flush cycle is the detection cycle itself
  always_comb begin
    state_n = state;
    rem_n = rem;
    do_stall = 1'b0;
    do_flush = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (!mem_busy) begin
      if (state == LOAD_STALL) begin
        do_stall = 1'b1;
        rem_n = rem - 4'd1;
        state_n = rem == 4'd1 ? IDLE : LOAD_STALL;
      end else if (state == FLUSH) begin
        do_flush = 1'b1;
        rem_n = rem - 4'd1;
        state_n = rem == 4'd1 ? IDLE : FLUSH;
      end else if (hz) begin
        do_stall = 1'b1;
        stall_inc = 1'b1;
        state_n = LOAD_STALL_CYCLES > 1 ? LOAD_STALL : IDLE;
        rem_n = 4'(LOAD_STALL_CYCLES - 1);
      end else if (taken) begin
        do_flush = 1'b1;
        flush_inc = 1'b1;
        state_n = FLUSH_CYCLES > 1 ? FLUSH : IDLE;
        rem_n = 4'(FLUSH_CYCLES - 1);
      end
    end
  end
  assign pc_write = !mem_busy && !do_stall;
  assign IF_ID_write = !mem_busy && !do_stall;
  assign mux_hz_unit = !do_stall;
  assign flush = do_flush;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      rem <= '0;
      stall_events <= '0;
      flush_events <= '0;
    end else begin
      state <= state_n;
      rem <= rem_n;
      if (stall_inc && !(&stall_events)) stall_events <= stall_events + CNT_W'(1);
      if (flush_inc && !(&flush_events)) flush_events <= flush_events + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: directed vectors against three parameterisations sharing one stimulus.
module tb_hazard_control_unit;
  logic clk = 1'b0, rst;
  logic [4:0] ex_rt, id_rs, id_rt;
  logic mem_read, equal, mem_busy, cnt_en;
  logic [1:0] branch;
  logic pw_a, iw_a, mx_a, fl_a, pw_b, iw_b, mx_b, fl_b, pw_c, iw_c, mx_c, fl_c;
  logic [15:0] se_a, fe_a, se_b, fe_b;
  logic [1:0] se_c, fe_c;
  logic [3:0] ca, cb;
  int checks = 0, failures = 0, lowcnt = 0;
  localparam logic [3:0] P = 4'b1110, S = 4'b0000, F = 4'b1111, Z = 4'b0010;
  assign ca = {pw_a, iw_a, mx_a, fl_a};
  assign cb = {pw_b, iw_b, mx_b, fl_b};
  always #5 clk = ~clk;
  hazard_control_unit dut_a (.clk(clk), .rst(rst), .ID_EX_rt(ex_rt), .ID_EX_mem_read(mem_read),
    .IF_ID_rs(id_rs), .IF_ID_rt(id_rt), .branch(branch), .equal(equal), .mem_busy(mem_busy),
    .pc_write(pw_a), .IF_ID_write(iw_a), .mux_hz_unit(mx_a), .flush(fl_a),
    .stall_events(se_a), .flush_events(fe_a));
  hazard_control_unit #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(2), .ZERO_REG_EXEMPT(0)) dut_b (
    .clk(clk), .rst(rst), .ID_EX_rt(ex_rt), .ID_EX_mem_read(mem_read),
    .IF_ID_rs(id_rs), .IF_ID_rt(id_rt), .branch(branch), .equal(equal), .mem_busy(mem_busy),
    .pc_write(pw_b), .IF_ID_write(iw_b), .mux_hz_unit(mx_b), .flush(fl_b),
    .stall_events(se_b), .flush_events(fe_b));
  hazard_control_unit #(.CNT_W(2)) dut_c (.clk(clk), .rst(rst), .ID_EX_rt(ex_rt),
    .ID_EX_mem_read(mem_read), .IF_ID_rs(id_rs), .IF_ID_rt(id_rt), .branch(branch),
    .equal(equal), .mem_busy(mem_busy), .pc_write(pw_c), .IF_ID_write(iw_c), .mux_hz_unit(mx_c),
    .flush(fl_c), .stall_events(se_c), .flush_events(fe_c));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic set(input logic [4:0] rt_ex, input logic mr, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [1:0] br, input logic eq, input logic mb);
    ex_rt = rt_ex; mem_read = mr; id_rs = rs; id_rt = rt; branch = br; equal = eq; mem_busy = mb;
  endtask
  task automatic idle();
    set(5'd0, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
  endtask
  task automatic step(input string tag, input logic [3:0] ea, input logic [3:0] eb);
    #2;
    chk({tag, ".a"}, 32'(ca), 32'(ea));
    chk({tag, ".b"}, 32'(cb), 32'(eb));
    if (cnt_en && !cb[3]) lowcnt++;
    @(negedge clk);
  endtask
  initial begin
    cnt_en = 1'b0;
    rst = 1'b0;
    idle();
    @(negedge clk);
    #2;
    chk("rst_ctl.a", 32'(ca), 32'(P));
    chk("rst_ctl.b", 32'(cb), 32'(P));
    chk("rst_cnt.a", 32'(se_a), 0);
    chk("rst_cnt.b", 32'(fe_b), 0);
    @(negedge clk);
    rst = 1'b1;
    set(5'd8, 1'b1, 5'd8, 5'd3, 2'b00, 1'b0, 1'b0);
    step("ld_rs", S, S);
    idle();
    step("ld_rs1", P, S);
    chk("ld_rs_cnt.a", 32'(se_a), 1);
    step("ld_rs2", P, S);
    step("ld_rs3", P, P);
    chk("ld_rs_cnt.b", 32'(se_b), 1);
    set(5'd4, 1'b1, 5'd1, 5'd4, 2'b00, 1'b0, 1'b0);
    step("ld_rt", S, S);
    idle();
    step("ld_rt1", P, S);
    step("ld_rt2", P, S);
    step("ld_rt3", P, P);
    chk("ld_rt_cnt.a", 32'(se_a), 2);
    chk("ld_rt_cnt.b", 32'(se_b), 2);
    set(5'd0, 1'b1, 5'd0, 5'd5, 2'b00, 1'b0, 1'b0);
    step("ld_r0", P, S);
    idle();
    step("ld_r0_1", P, S);
    step("ld_r0_2", P, S);
    step("ld_r0_3", P, P);
    chk("ld_r0_cnt.a", 32'(se_a), 2);
    chk("ld_r0_cnt.b", 32'(se_b), 3);
    set(5'd0, 1'b0, 5'd0, 5'd0, 2'b10, 1'b0, 1'b0);
    step("bne_t", F, F);
    idle();
    step("br_none", P, F);
    step("br_none2", P, P);
    chk("bne_cnt.a", 32'(fe_a), 1);
    chk("bne_cnt.b", 32'(fe_b), 1);
    set(5'd0, 1'b0, 5'd0, 5'd0, 2'b10, 1'b1, 1'b0);
    step("bne_nt", P, P);
    set(5'd0, 1'b0, 5'd0, 5'd0, 2'b01, 1'b1, 1'b0);
    step("beq_t", F, F);
    idle();
    step("beq_t1", P, F);
    step("beq_t2", P, P);
    chk("beq_cnt.a", 32'(fe_a), 2);
    chk("beq_cnt.b", 32'(fe_b), 2);
    set(5'd7, 1'b1, 5'd7, 5'd0, 2'b11, 1'b0, 1'b0);
    step("hz_jmp", S, S);
    chk("hz_jmp_fe.a", 32'(fe_a), 2);
    chk("hz_jmp_se.a", 32'(se_a), 3);
    set(5'd7, 1'b0, 5'd7, 5'd0, 2'b11, 1'b0, 1'b0);
    step("jmp1", F, S);
    step("jmp2", F, S);
    step("jmp3", F, F);
    idle();
    step("jmp4", P, F);
    step("jmp5", P, P);
    chk("jmp_fe.a", 32'(fe_a), 5);
    chk("jmp_fe.b", 32'(fe_b), 3);
    chk("jmp_se.b", 32'(se_b), 4);
    cnt_en = 1'b1;
    set(5'd9, 1'b1, 5'd9, 5'd0, 2'b00, 1'b0, 1'b0);
    step("frz_hz", S, S);
    set(5'd0, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1);
    repeat (4) step("frz", Z, Z);
    idle();
    step("frz_end1", P, S);
    step("frz_end2", P, S);
    step("frz_end3", P, P);
    cnt_en = 1'b0;
    chk("frz_len.b", 32'(lowcnt), 7);
    chk("frz_se.a", 32'(se_a), 4);
    chk("frz_se.b", 32'(se_b), 5);
    set(5'd9, 1'b1, 5'd9, 5'd0, 2'b00, 1'b0, 1'b0);
    step("rs_hz", S, S);
    idle();
    #2;
    chk("rs_mid.b", 32'(cb), 32'(S));
    rst = 1'b0;
    #1;
    chk("rs_ctl.a", 32'(ca), 32'(P));
    chk("rs_ctl.b", 32'(cb), 32'(P));
    chk("rs_se.b", 32'(se_b), 0);
    chk("rs_se.a", 32'(se_a), 0);
    chk("rs_fe.b", 32'(fe_b), 0);
    @(negedge clk);
    rst = 1'b1;
    set(5'd3, 1'b1, 5'd3, 5'd0, 2'b00, 1'b0, 1'b0);
    repeat (5) step("sat", S, S);
    idle();
    chk("sat_se.a", 32'(se_a), 5);
    chk("sat_se.c", 32'(se_c), 3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Parametrised, stateful successor to the pipeline's load-use and branch hazard logic.
- Sits between the ID stage and the PC, IF/ID and ID/EX control mux. Produces the stall, bubble and flush controls.
- Additions over the current logic:
  - configurable load-use bubble depth and flush depth;
  - multi-cycle memory freeze;
  - register-0 exemption;
  - a defined (latch-free) flush;
  - saturating event counters for performance debug.

Parameters:
- REG_ADDR_W, 5, register address width.
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..15).
- FLUSH_CYCLES, 1, cycles flush is held per taken branch/jump (1..15).
- ZERO_REG_EXEMPT, 1, when 1 a load targeting register 0 never causes a stall.
- CNT_W, 16, width of the event counters.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- ID_EX_rt  input  REG_ADDR_W  destination of the instruction in EX.
- ID_EX_mem_read  input  1  the instruction in EX is a load.
- IF_ID_rs  input  REG_ADDR_W  rs of the instruction in ID.
- IF_ID_rt  input  REG_ADDR_W  rt of the instruction in ID.
- branch  input  2  00 none, 01 beq, 10 bne, 11 jump.
- equal  input  1  ID-stage comparator result.
- mem_busy  input  1  data memory not ready; freeze the pipeline.
- pc_write  output  1  PC update enable.
- IF_ID_write  output  1  IF/ID register enable.
- mux_hz_unit  output  1  1 passes ID control, 0 inserts a bubble.
- flush  output  1  flush IF/ID.
- stall_events  output  CNT_W  saturating count of load-use hazards.
- flush_events  output  CNT_W  saturating count of taken branches/jumps.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, counters=0;
  - pc_write=1, IF_ID_write=1, mux_hz_unit=1, flush=0.
- Detection terms (combinational):
  - hz = ID_EX_mem_read & (IF_ID_rs==ID_EX_rt | IF_ID_rt==ID_EX_rt) & !(ZERO_REG_EXEMPT & ID_EX_rt==0).
  - taken = (branch==01 & equal) | (branch==10 & !equal) | (branch==11).
- States: IDLE, LOAD_STALL, FLUSH, plus a down-counter rem (4 bits).
- Outputs are Mealy in IDLE, so the first stall or flush cycle takes effect in the detection cycle (zero latency).
- Priority within any cycle: mem_busy > load stall > flush.
  - mem_busy=1: pc_write=0, IF_ID_write=0, mux_hz_unit=1, flush=0. State, rem and counters hold.
- IDLE:
  - hz=1: pc_write=0, IF_ID_write=0, mux_hz_unit=0, flush=0; stall_events++.
    - If LOAD_STALL_CYCLES>1: go to LOAD_STALL with rem=LOAD_STALL_CYCLES-1.
  - Else if taken=1: flush=1, all other controls pass; flush_events++.
    - If FLUSH_CYCLES>1: go to FLUSH with rem=FLUSH_CYCLES-1.
  - A branch that coincides with hz is suppressed, not counted. It re-evaluates after the stall, when the ID instruction is unchanged.
  - Otherwise all pass, flush=0. Flush is never left at a stale value.
- LOAD_STALL:
  - Stall outputs as above each cycle; rem--. Return to IDLE when rem reaches 1 at the clock edge.
  - hz and taken are ignored here.
- FLUSH:
  - flush=1 and others pass each cycle; rem--. Return to IDLE when rem reaches 1.
  - Load-use detection is ignored, because IF/ID holds a flushed instruction.
- Counters: increment once per event, not per cycle; saturate at all-ones with no wrap.
- Reset mid-stall or mid-flush: immediate return to IDLE and pass-through outputs.

Test Plan:
- Reset, then load r8 in EX with r8 as rs in ID → same cycle: pc_write=0, IF_ID_write=0, mux_hz_unit=0. Next cycle (hz cleared): all 1. stall_events=1.
- LOAD_STALL_CYCLES=3, load r4 with r4 as rt in ID → stall outputs for exactly 3 consecutive cycles, then pass; stall_events=1.
- Load r0 with rs=0: ZERO_REG_EXEMPT=1 → no stall; ZERO_REG_EXEMPT=0 → 1-cycle stall.
- branch=10, equal=0 → flush=1 for FLUSH_CYCLES cycles (check 1 and 2). branch=10, equal=1 → flush=0. branch=00 after a taken branch → flush=0.
- hz and branch=11 in the same cycle → stall only, flush=0. Next cycle (hz=0, branch=11) → flush=1; counters 1/1.
- mem_busy=1 for 4 cycles in the middle of a 3-cycle LOAD_STALL → pc_write=0 throughout. Total stall+freeze is 7 cycles. Separately, asserting rst low mid-stall → outputs return to pass-through immediately and counters read 0.
